// File: rtl/imem_arbiter_pkg.sv
// Shared types and constants for the instruction-memory arbiter:
// arbitration state, response owner tag and address range helper.
package imem_arbiter_pkg;

    localparam int unsigned IMEM_DEPTH  = 3001;
    localparam int          IMEM_DATA_W = 32;

    typedef enum logic {
        ST_SHARED = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_e;

    function automatic logic addr_in_range(input logic [63:0] addr, input int unsigned depth);
        return addr < 64'(depth);
    endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch, loader and memory-side signals of the arbiter bundled as one interface.
// The arbiter uses the slave view; requesters and the memory model use master.
interface imem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic                                   f_req;
    logic [ADDR_W-1:0]                      f_addr;
    logic                                   f_gnt;
    logic                                   f_rvalid;
    logic [imem_arbiter_pkg::IMEM_DATA_W-1:0] f_rdata;
    logic                                   f_err;

    logic                                   l_req;
    logic                                   l_we;
    logic                                   l_lock;
    logic [ADDR_W-1:0]                      l_addr;
    logic [imem_arbiter_pkg::IMEM_DATA_W-1:0] l_wdata;
    logic                                   l_gnt;
    logic                                   l_rvalid;
    logic [imem_arbiter_pkg::IMEM_DATA_W-1:0] l_rdata;
    logic                                   l_err;

    logic                                   m_ce;
    logic                                   m_we;
    logic [ADDR_W-1:0]                      m_addr;
    logic [imem_arbiter_pkg::IMEM_DATA_W-1:0] m_d;
    logic [imem_arbiter_pkg::IMEM_DATA_W-1:0] m_q;

    modport slave (
        input  f_req, f_addr, l_req, l_we, l_lock, l_addr, l_wdata, m_q,
        output f_gnt, f_rvalid, f_rdata, f_err,
        output l_gnt, l_rvalid, l_rdata, l_err,
        output m_ce, m_we, m_addr, m_d
    );

    modport master (
        output f_req, f_addr, l_req, l_we, l_lock, l_addr, l_wdata, m_q,
        input  f_gnt, f_rvalid, f_rdata, f_err,
        input  l_gnt, l_rvalid, l_rdata, l_err,
        input  m_ce, m_we, m_addr, m_d
    );

endinterface

// File: rtl/imem_resp_tag.sv
// One-cycle response tag: remembers who was granted and whether the access
// errored or was a write, then steers the memory read data to that port.
module imem_resp_tag
    import imem_arbiter_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   f_gnt_i,
    input  logic                   l_gnt_i,
    input  logic                   err_i,
    input  logic                   wr_i,
    input  logic [IMEM_DATA_W-1:0] m_q_i,
    output logic                   f_rvalid_o,
    output logic                   f_err_o,
    output logic [IMEM_DATA_W-1:0] f_rdata_o,
    output logic                   l_rvalid_o,
    output logic                   l_err_o,
    output logic [IMEM_DATA_W-1:0] l_rdata_o
);

    owner_e owner_q, owner_d;
    logic   err_q, err_d;
    logic   wr_q, wr_d;
    logic   fwd_data;

    always_comb begin
        owner_d = OWN_NONE;
        if (f_gnt_i) begin
            owner_d = OWN_FETCH;
        end else if (l_gnt_i) begin
            owner_d = OWN_LOAD;
        end
        err_d = (f_gnt_i | l_gnt_i) & err_i;
        wr_d  = l_gnt_i & wr_i & ~err_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_q <= OWN_NONE;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            owner_q <= owner_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
        end
    end

    // Outputs are gated by rst so a response in flight never escapes during reset.
    assign fwd_data   = ~err_q & ~wr_q;
    assign f_rvalid_o = ~rst_i & (owner_q == OWN_FETCH);
    assign l_rvalid_o = ~rst_i & (owner_q == OWN_LOAD);
    assign f_err_o    = f_rvalid_o & err_q;
    assign l_err_o    = l_rvalid_o & err_q;
    assign f_rdata_o  = (f_rvalid_o & fwd_data) ? m_q_i : '0;
    assign l_rdata_o  = (l_rvalid_o & fwd_data) ? m_q_i : '0;

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates a single-port instruction memory between the fetch unit and a
// loader, with a loader lock mode and a starvation guard for fetch.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH    = IMEM_DEPTH,
    parameter int          ADDR_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    imem_arbiter_if.slave bus
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    arb_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              f_gnt, l_gnt;
    logic              conflict, f_ok, l_ok;

    assign conflict = bus.f_req & bus.l_req;
    assign f_ok     = addr_in_range(64'(bus.f_addr), DEPTH);
    assign l_ok     = addr_in_range(64'(bus.l_addr), DEPTH);

    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (!rst) begin
            if (state_q == ST_LOCKED) begin
                l_gnt = bus.l_req;
            end else if (conflict) begin
                if (wait_q == WAIT_W'(MAX_WAIT)) begin
                    f_gnt = 1'b1;
                end else begin
                    l_gnt = 1'b1;
                end
            end else begin
                f_gnt = bus.f_req;
                l_gnt = bus.l_req;
            end
        end

        state_d = state_q;
        if (state_q == ST_LOCKED) begin
            if (!bus.l_lock) state_d = ST_SHARED;
        end else if (l_gnt && bus.l_lock) begin
            state_d = ST_LOCKED;
        end

        // Only contested cycles the loader wins count towards forcing a fetch.
        wait_d = wait_q;
        if (f_gnt) begin
            wait_d = '0;
        end else if (state_q == ST_SHARED && conflict && l_gnt && wait_q != WAIT_W'(MAX_WAIT)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_SHARED;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign bus.f_gnt  = f_gnt;
    assign bus.l_gnt  = l_gnt;
    assign bus.m_ce   = (f_gnt & f_ok) | (l_gnt & l_ok);
    assign bus.m_we   = l_gnt & l_ok & bus.l_we;
    assign bus.m_addr = f_gnt ? bus.f_addr : bus.l_addr;
    assign bus.m_d    = l_gnt ? bus.l_wdata : '0;

    imem_resp_tag u_resp_tag (
        .clk_i      (clk),
        .rst_i      (rst),
        .f_gnt_i    (f_gnt),
        .l_gnt_i    (l_gnt),
        .err_i      (f_gnt ? ~f_ok : ~l_ok),
        .wr_i       (bus.l_we),
        .m_q_i      (bus.m_q),
        .f_rvalid_o (bus.f_rvalid),
        .f_err_o    (bus.f_err),
        .f_rdata_o  (bus.f_rdata),
        .l_rvalid_o (bus.l_rvalid),
        .l_err_o    (bus.l_err),
        .l_rdata_o  (bus.l_rdata)
    );

endmodule
